game_tick_scheduler: RTL and testbench
======================================

Name: game_tick_scheduler

Overview:
Generates the two-bit game_tick strobe that paces the player controller, obstacle and score logic from the per-frame video strobe. bit0 is the input-sample tick (every frame, all states). bit1 is the physics/scroll tick (every N frames, only while a game is running). N shrinks as the game progresses, giving a difficulty ramp, and is frozen on game over for display.

Parameters:
START_PERIOD, 8, frames per physics tick at game start
MIN_PERIOD, 2, fastest allowed frames per physics tick
LEVEL_STEPS, 256, physics ticks per difficulty step
PERIOD_W, 4, width of period/frame counters; constraint 1 <= MIN_PERIOD <= START_PERIOD < 2^PERIOD_W

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
frame_pulse  in  1  one-cycle strobe, once per video frame
game_start_pulse  in  1  one-cycle request to start/restart a game
game_over_pulse  in  1  one-cycle request to end the running game
game_tick  out  2  registered strobes; [0] input-sample tick, [1] physics tick
speed_level  out  4  difficulty level, 0 at game start, saturating
period  out  PERIOD_W  current frames per physics tick
sched_state  out  2  00 IDLE, 01 RUN, 10 OVER

Behaviour:
- Reset (rst_n low at clk edge): sched_state=IDLE, game_tick=00, speed_level=0, period=START_PERIOD, frame_cnt=0, step_cnt=0. Reset mid-RUN takes effect on the next edge and has priority over all inputs.
- All outputs are registered. Latency from frame_pulse to game_tick is 1 cycle. Each game_tick bit is high for exactly one cycle.
- game_tick[0] <= frame_pulse in every state.
- FSM:
  - IDLE: game_start_pulse -> RUN. game_over_pulse ignored.
  - RUN: game_over_pulse -> OVER. game_start_pulse ignored.
  - OVER: game_start_pulse -> RUN. game_over_pulse ignored.
  - Encoding 11 is illegal -> IDLE on next edge.
- Entering RUN (from IDLE or OVER): frame_cnt=0, step_cnt=0, period=START_PERIOD, speed_level=0.
- Frame divider, only in RUN, on frame_pulse:
  - If frame_cnt == period-1: frame_cnt<=0, game_tick[1]<=1, step_cnt advances.
  - Otherwise frame_cnt<=frame_cnt+1.
  - game_tick[1] therefore always coincides with a game_tick[0] cycle.
  - First physics tick comes on the START_PERIOD-th frame_pulse after entry.
- Difficulty step:
  - When a physics tick is issued with step_cnt == LEVEL_STEPS-1, step_cnt<=0; otherwise step_cnt<=step_cnt+1.
  - On that wrap, if period > MIN_PERIOD: period<=period-1 and speed_level<=speed_level+1 (saturating at 15).
  - At MIN_PERIOD, period and speed_level hold.
  - The new period governs the next frame count (frame_cnt has just cleared, so there is no partial interval).
  - step_cnt width is max(1, clog2(LEVEL_STEPS)). LEVEL_STEPS=1 means a step on every physics tick.
- Simultaneous events:
  - RUN with game_over_pulse and frame_pulse in the same cycle: over wins. No game_tick[1] is produced for that frame, counters are not updated, game_tick[0] is still produced.
  - IDLE/OVER with game_start_pulse and frame_pulse in the same cycle: enter RUN with counters cleared. That frame is not counted. game_tick[0] is still produced.
- OVER: game_tick[1] never asserts. period and speed_level hold their final values. frame_cnt and step_cnt are frozen.
- IDLE: game_tick[1] never asserts.

Test Plan:
1. Reset, frame_pulse every 4 cycles, no start -> game_tick[0] high 1 cycle after each frame_pulse, game_tick[1]=0, sched_state=00, period=8, speed_level=0.
2. Defaults, start, then frame_pulse train -> first game_tick=11 one cycle after the 8th frame_pulse post-start, then every 8th frame; all other frames give 01.
3. LEVEL_STEPS=4, START_PERIOD=4, MIN_PERIOD=2 ->
   - after 4 physics ticks: period=3, speed_level=1, next tick after 3 frames;
   - after 4 more: period=2, speed_level=2;
   - after a further 8 ticks: still 2/2.
4. In RUN, game_over_pulse in the same cycle as the frame that would complete a period -> game_tick=01 (no bit1), sched_state=10, period/speed_level unchanged, later frames give 01 only.
5. From OVER (period=2, speed_level=2), game_start_pulse together with frame_pulse -> sched_state=01, period=START_PERIOD, speed_level=0, that frame not counted, first bit1 after START_PERIOD further frames.
6. rst_n low for 1 cycle mid-RUN with frame_cnt=5, speed_level=1 -> next cycle all reset values, sched_state=00; game_start_pulse then restarts cleanly.

Source files
------------

// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler: derives the per-frame input-sample tick and the
// slower physics/scroll tick from the video frame strobe. The physics
// interval shrinks by one frame every LEVEL_STEPS physics ticks until it
// reaches MIN_PERIOD, and is frozen on game over.
module game_tick_scheduler #(
   parameter int START_PERIOD = 8,
   parameter int MIN_PERIOD   = 2,
   parameter int LEVEL_STEPS  = 256,
   parameter int PERIOD_W     = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                frame_pulse,
   input  logic                game_start_pulse,
   input  logic                game_over_pulse,
   output logic [1:0]          game_tick,
   output logic [3:0]          speed_level,
   output logic [PERIOD_W-1:0] period,
   output logic [1:0]          sched_state
);

   localparam int STEP_W = (LEVEL_STEPS > 1) ? $clog2(LEVEL_STEPS) : 1;

   localparam logic [PERIOD_W-1:0] START_P   = PERIOD_W'(START_PERIOD);
   localparam logic [PERIOD_W-1:0] MIN_P     = PERIOD_W'(MIN_PERIOD);
   localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(LEVEL_STEPS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_OVER = 2'b10
   } state_e;

   state_e              state_q, state_d;
   logic [1:0]          game_tick_q, game_tick_d;
   logic [3:0]          speed_level_q, speed_level_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;

   // Next-state, divider and difficulty ramp; everything holds by default.
   always_comb begin
      state_d       = state_q;
      game_tick_d   = {1'b0, frame_pulse};
      speed_level_d = speed_level_q;
      period_d      = period_q;
      frame_cnt_d   = frame_cnt_q;
      step_cnt_d    = step_cnt_q;

      case (state_q)
         S_IDLE, S_OVER: begin
            // A frame arriving with the start request is not counted.
            if (game_start_pulse) begin
               state_d       = S_RUN;
               frame_cnt_d   = '0;
               step_cnt_d    = '0;
               period_d      = START_P;
               speed_level_d = '0;
            end
         end
         S_RUN: begin
            // Game over wins over a coincident frame: no physics tick and
            // the counters stay frozen where they were.
            if (game_over_pulse) begin
               state_d = S_OVER;
            end else if (frame_pulse) begin
               if (frame_cnt_q == period_q - PERIOD_W'(1)) begin
                  frame_cnt_d    = '0;
                  game_tick_d[1] = 1'b1;
                  if (step_cnt_q == STEP_LAST) begin
                     step_cnt_d = '0;
                     // Frame count has just cleared, so a shorter period
                     // applies cleanly from the next frame.
                     if (period_q > MIN_P) begin
                        period_d = period_q - PERIOD_W'(1);
                        if (speed_level_q != 4'hF)
                           speed_level_d = speed_level_q + 4'd1;
                     end
                  end else begin
                     step_cnt_d = step_cnt_q + STEP_W'(1);
                  end
               end else begin
                  frame_cnt_d = frame_cnt_q + PERIOD_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and counter registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         game_tick_q   <= '0;
         speed_level_q <= '0;
         period_q      <= START_P;
         frame_cnt_q   <= '0;
         step_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         game_tick_q   <= game_tick_d;
         speed_level_q <= speed_level_d;
         period_q      <= period_d;
         frame_cnt_q   <= frame_cnt_d;
         step_cnt_q    <= step_cnt_d;
      end
   end

   assign game_tick   = game_tick_q;
   assign speed_level = speed_level_q;
   assign period      = period_q;
   assign sched_state = state_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench: one default-parameter instance (a) and one fast-ramp
// instance (b: START 4, MIN 2, LEVEL_STEPS 4) share the same stimulus.
module tb_game_tick_scheduler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_pulse = 1'b0;
   logic       game_start_pulse = 1'b0;
   logic       game_over_pulse = 1'b0;

   logic [1:0] tick_a, tick_b;
   logic [3:0] lvl_a, lvl_b;
   logic [3:0] per_a, per_b;
   logic [1:0] st_a, st_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   game_tick_scheduler dut_a (
      .clk(clk), .rst_n(rst_n), .frame_pulse(frame_pulse),
      .game_start_pulse(game_start_pulse), .game_over_pulse(game_over_pulse),
      .game_tick(tick_a), .speed_level(lvl_a), .period(per_a),
      .sched_state(st_a)
   );

   game_tick_scheduler #(.START_PERIOD(4), .MIN_PERIOD(2), .LEVEL_STEPS(4),
                         .PERIOD_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .frame_pulse(frame_pulse),
      .game_start_pulse(game_start_pulse), .game_over_pulse(game_over_pulse),
      .game_tick(tick_b), .speed_level(lvl_b), .period(per_b),
      .sched_state(st_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs starting at a falling edge; outputs are
   // sampled at the next falling edge, after the registering rising edge.
   task automatic step(input logic fp, input logic st, input logic ov);
      frame_pulse      = fp;
      game_start_pulse = st;
      game_over_pulse  = ov;
      @(negedge clk);
      frame_pulse      = 1'b0;
      game_start_pulse = 1'b0;
      game_over_pulse  = 1'b0;
   endtask

   // One frame followed by one quiet cycle; checks both tick vectors.
   task automatic frame(input string tag, input logic [1:0] ea,
                        input logic [1:0] eb);
      step(1'b1, 1'b0, 1'b0);
      chk({tag, "_tick_a"}, 32'(tick_a), 32'(ea));
      chk({tag, "_tick_b"}, 32'(tick_b), 32'(eb));
      step(1'b0, 1'b0, 1'b0);
      chk({tag, "_quiet"}, 32'({tick_a, tick_b}), 32'h0);
   endtask

   initial begin
      // Reset
      @(negedge clk);
      @(negedge clk);
      chk("rst_state_a", 32'(st_a), 32'h0);
      chk("rst_tick_a", 32'(tick_a), 32'h0);
      chk("rst_per_a", 32'(per_a), 32'd8);
      chk("rst_per_b", 32'(per_b), 32'd4);
      chk("rst_lvl", 32'({lvl_a, lvl_b}), 32'h0);
      rst_n = 1'b1;

      // 1: IDLE, frames every 4 cycles, over pulse ignored
      for (int i = 0; i < 3; i++) begin
         frame("idle", 2'b01, 2'b01);
         step(1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b0);
      end
      step(1'b0, 1'b0, 1'b1);
      chk("idle_over_ign", 32'(st_a), 32'h0);
      chk("idle_per", 32'(per_a), 32'd8);

      // 2: start, then frames; a start pulse in RUN is ignored
      step(1'b0, 1'b1, 1'b0);
      chk("start_state_a", 32'(st_a), 32'h1);
      chk("start_state_b", 32'(st_b), 32'h1);
      for (int f = 1; f <= 8; f++) begin
         frame("run", (f == 8) ? 2'b11 : 2'b01, (f % 4 == 0) ? 2'b11 : 2'b01);
         if (f == 2) step(1'b0, 1'b1, 1'b0);
      end
      chk("run_state", 32'(st_a), 32'h1);

      // 3: difficulty ramp on b (a keeps period 8)
      for (int f = 9; f <= 16; f++)
         frame("ramp0", (f % 8 == 0) ? 2'b11 : 2'b01,
               (f % 4 == 0) ? 2'b11 : 2'b01);
      chk("lvl1_per_b", 32'(per_b), 32'd3);
      chk("lvl1_lvl_b", 32'(lvl_b), 32'd1);
      for (int f = 17; f <= 28; f++)
         frame("ramp1", (f == 24) ? 2'b11 : 2'b01,
               (f == 19 || f == 22 || f == 25 || f == 28) ? 2'b11 : 2'b01);
      chk("lvl2_per_b", 32'(per_b), 32'd2);
      chk("lvl2_lvl_b", 32'(lvl_b), 32'd2);
      chk("lvl2_per_a", 32'(per_a), 32'd8);
      chk("lvl2_lvl_a", 32'(lvl_a), 32'd0);
      for (int f = 29; f <= 44; f++)
         frame("ramp2", (f % 8 == 0) ? 2'b11 : 2'b01,
               (f % 2 == 0) ? 2'b11 : 2'b01);
      chk("sat_per_b", 32'(per_b), 32'd2);
      chk("sat_lvl_b", 32'(lvl_b), 32'd2);

      // 4: over coincides with b's period-completing frame
      frame("pre_over", 2'b01, 2'b01);
      step(1'b1, 1'b0, 1'b1);
      chk("over_tick_a", 32'(tick_a), 32'h1);
      chk("over_tick_b", 32'(tick_b), 32'h1);
      chk("over_state_a", 32'(st_a), 32'h2);
      chk("over_state_b", 32'(st_b), 32'h2);
      chk("over_per_b", 32'(per_b), 32'd2);
      chk("over_lvl_b", 32'(lvl_b), 32'd2);
      for (int f = 0; f < 3; f++) frame("over", 2'b01, 2'b01);
      chk("over_hold_per", 32'(per_b), 32'd2);

      // 5: restart from OVER with a coincident frame (not counted)
      step(1'b1, 1'b1, 1'b0);
      chk("restart_tick", 32'({tick_a, tick_b}), 32'h5);
      chk("restart_state_b", 32'(st_b), 32'h1);
      chk("restart_per_b", 32'(per_b), 32'd4);
      chk("restart_lvl_b", 32'(lvl_b), 32'd0);
      for (int f = 1; f <= 16; f++)
         frame("rerun", (f % 8 == 0) ? 2'b11 : 2'b01,
               (f % 4 == 0) ? 2'b11 : 2'b01);
      chk("rerun_per_b", 32'(per_b), 32'd3);
      chk("rerun_lvl_b", 32'(lvl_b), 32'd1);
      for (int f = 17; f <= 21; f++)
         frame("rerun2", 2'b01, (f == 19) ? 2'b11 : 2'b01);

      // 6: reset mid-RUN (a frame_cnt=5) beats coincident inputs
      rst_n = 1'b0;
      step(1'b1, 1'b0, 1'b1);
      rst_n = 1'b1;
      chk("mrst_tick", 32'({tick_a, tick_b}), 32'h0);
      chk("mrst_state", 32'({st_a, st_b}), 32'h0);
      chk("mrst_per_a", 32'(per_a), 32'd8);
      chk("mrst_per_b", 32'(per_b), 32'd4);
      chk("mrst_lvl_b", 32'(lvl_b), 32'd0);
      step(1'b0, 1'b1, 1'b0);
      chk("mrst_start", 32'({st_a, st_b}), 32'h5);
      for (int f = 1; f <= 8; f++)
         frame("post_rst", (f == 8) ? 2'b11 : 2'b01,
               (f % 4 == 0) ? 2'b11 : 2'b01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Safety net so the run can never hang.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
